// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory responder: state encoding,
// default bus widths and the wait-state load helper.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_READ   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // WAIT exits on the zero flag, so a W-cycle wait loads W-1.
    function automatic logic [3:0] wait_load(input int unsigned w);
        return (w == 0) ? 4'd0 : 4'(w - 1);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit down-counter timing the wait states; loaded on request acceptance,
// decremented while counting, flags zero when the wait has elapsed.
module wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       count,
    output logic       zero
);

    logic [3:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// CPU request responder in front of a dual-port block RAM: writes go through
// port A, reads through port B, with a configurable number of wait states.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb
);

    state_t            state;
    state_t            state_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              acc_we;
    logic              cnt_zero;

    assign accept = (state == ST_IDLE) && req;
    // Direction for the upcoming ACCESS: the latch is not yet loaded when
    // ACCESS follows acceptance directly.
    assign acc_we = accept ? we : we_q;

    wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (wait_load(WAIT_CYCLES)),
        .count    (state == ST_WAIT),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req) state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (cnt_zero) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = we_q ? ST_RESP : ST_READ;
            ST_READ:   state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: Moore outputs are registered from the next state so they line up
    // with the state register; the async reset clears them with no clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            ram_ena <= 1'b0;
            ram_wea <= 1'b0;
            ram_enb <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == ST_READ) begin
                rdata <= ram_doutb;
            end
            ready   <= (state_nxt == ST_RESP);
            busy    <= (state_nxt != ST_IDLE);
            ram_ena <= (state_nxt == ST_ACCESS) && acc_we;
            ram_wea <= (state_nxt == ST_ACCESS) && acc_we;
            ram_enb <= (state_nxt == ST_ACCESS) && !acc_we;
        end
    end

    assign ram_addra = addr_q;
    assign ram_addrb = addr_q;
    assign ram_dina  = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: behavioural RAMs, a reference memory
// model and a read-data scoreboard queue.
module tb_mem_responder;

    localparam int WC = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT with one wait state
    logic        req, we, ready, busy, ram_ena, ram_wea, ram_enb;
    logic [7:0]  addr, ram_addra, ram_addrb;
    logic [31:0] wdata, rdata, ram_dina, ram_doutb;
    // DUT with zero wait states
    logic        req_z, we_z, ready_z, busy_z, ram_ena_z, ram_wea_z, ram_enb_z;
    logic [7:0]  addr_z, ram_addra_z, ram_addrb_z;
    logic [31:0] wdata_z, rdata_z, ram_dina_z, ram_doutb_z;

    logic [31:0] mem1 [256];
    logic [31:0] mem0 [256];
    logic [31:0] model_mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] last_rdata;
    logic        init_mem;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .busy(busy),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
        .ready(ready_z), .rdata(rdata_z), .busy(busy_z),
        .ram_ena(ram_ena_z), .ram_wea(ram_wea_z), .ram_addra(ram_addra_z), .ram_dina(ram_dina_z),
        .ram_enb(ram_enb_z), .ram_addrb(ram_addrb_z), .ram_doutb(ram_doutb_z)
    );

    function automatic logic [31:0] pattern(input int i);
        if (i == 8'h40) return 32'h0000_AAAA;
        if (i == 5)     return 32'h1234_5678;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem1[i] <= pattern(i);
        end else if (ram_ena && ram_wea) begin
            mem1[ram_addra] <= ram_dina;
        end
        if (ram_enb) ram_doutb <= mem1[ram_addrb];
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem0[i] <= pattern(i);
        end else if (ram_ena_z && ram_wea_z) begin
            mem0[ram_addra_z] <= ram_dina_z;
        end
        if (ram_enb_z) ram_doutb_z <= mem0[ram_addrb_z];
    end

    // One request on the WAIT_CYCLES=1 DUT; optionally disturbs the fields in WAIT.
    task automatic do_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                             input bit change);
        int          k;
        int          exp_lat;
        bit          done;
        logic [31:0] exp;
        exp_lat = w ? WC + 1 : WC + 2;
        if (w) model_mem[a] = d;
        else   exp_q.push_back(model_mem[a]);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        if (change) begin
            addr = 8'h30; wdata = 32'h2;
        end
        k = 0; done = 1'b0;
        while (!done && k < 20) begin
            @(posedge clk); k++;
            @(negedge clk); done = ready;
        end
        req = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++; $display("FAIL ready_seen addr=%h: got %0d required 1", a, done);
        end
        n_checks++;
        if (k !== exp_lat) begin
            n_errors++; $display("FAIL latency addr=%h we=%0d: got %0d required %0d", a, w, k, exp_lat);
        end
        if (!w) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
            n_checks++;
            if (rdata !== exp) begin
                n_errors++; $display("FAIL read_data addr=%h: got %h required %h", a, rdata, exp);
            end
            last_rdata = exp;
        end else begin
            n_checks++;
            if (rdata !== last_rdata) begin
                n_errors++; $display("FAIL rdata_hold_on_write: got %h required %h", rdata, last_rdata);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++; $display("FAIL ready_pulse_width: got %b required 0", ready);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({ready, busy, ram_ena, ram_wea, ram_enb} !== 5'b0 || rdata !== 32'h0 || ram_addra !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_state: got ctl=%b rdata=%h addra=%h required 0", {ready, busy, ram_ena, ram_wea, ram_enb}, rdata, ram_addra);
        end
        n_checks++;
        if ({ready_z, busy_z, ram_ena_z, ram_wea_z, ram_enb_z} !== 5'b0 || rdata_z !== 32'h0) begin
            n_errors++; $display("FAIL reset_state_z: got ctl=%b rdata=%h required 0", {ready_z, busy_z, ram_ena_z, ram_wea_z, ram_enb_z}, rdata_z);
        end
    endtask

    task automatic test_write_read();
        do_access(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b0, 8'h10, 32'h0, 1'b0);
        do_access(1'b0, 8'h07, 32'h0, 1'b0);
    endtask

    task automatic test_zero_wait();
        int          k;
        int          enb_cnt;
        bit          done;
        logic [31:0] exp;
        exp_q.push_back(pattern(5));
        @(negedge clk);
        req_z = 1'b1; we_z = 1'b0; addr_z = 8'h05; wdata_z = 32'h0;
        @(posedge clk);
        @(negedge clk);
        enb_cnt = ram_enb_z ? 1 : 0;
        k = 0; done = 1'b0;
        while (!done && k < 20) begin
            @(posedge clk); k++;
            @(negedge clk); done = ready_z;
            if (ram_enb_z) enb_cnt++;
        end
        req_z = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
        n_checks++;
        if (k !== 2) begin
            n_errors++; $display("FAIL zero_wait_latency: got %0d required 2", k);
        end
        n_checks++;
        if (rdata_z !== exp) begin
            n_errors++; $display("FAIL zero_wait_rdata: got %h required %h", rdata_z, exp);
        end
        repeat (3) begin
            @(negedge clk);
            if (ram_enb_z) enb_cnt++;
        end
        n_checks++;
        if (enb_cnt !== 1) begin
            n_errors++; $display("FAIL zero_wait_enb_cycles: got %0d required 1", enb_cnt);
        end
    endtask

    task automatic test_busy_change();
        do_access(1'b1, 8'h20, 32'h1, 1'b1);
        n_checks++;
        if (mem1[8'h20] !== 32'h1) begin
            n_errors++; $display("FAIL latched_write_target: got %h required %h", mem1[8'h20], 32'h1);
        end
        n_checks++;
        if (mem1[8'h30] !== pattern(8'h30)) begin
            n_errors++; $display("FAIL untouched_addr: got %h required %h", mem1[8'h30], pattern(8'h30));
        end
        do_access(1'b0, 8'h20, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int npulse;
        bit idle_seen;
        bit gap_ok;
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) exp_q.push_back(model_mem[i]);
        npulse = 0; idle_seen = 1'b1; gap_ok = 1'b1;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) begin
                if (!idle_seen) gap_ok = 1'b0;
                idle_seen = 1'b0;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                n_checks++;
                if (rdata !== exp) begin
                    n_errors++; $display("FAIL b2b_data #%0d: got %h required %h", npulse, rdata, exp);
                end
                last_rdata = exp;
                npulse++;
                if (npulse < 3) addr = 8'(npulse);
                else            req = 1'b0;
            end else if (!busy) begin
                idle_seen = 1'b1;
            end
        end
        req = 1'b0;
        n_checks++;
        if (npulse !== 3) begin
            n_errors++; $display("FAIL b2b_pulse_count: got %0d required 3", npulse);
        end
        n_checks++;
        if (gap_ok !== 1'b1) begin
            n_errors++; $display("FAIL b2b_idle_gap: got %0d required 1", gap_ok);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ram_ena, ram_wea, ram_enb, busy, ready} !== 5'b0 || rdata !== last_rdata) begin
                n_errors++;
                $display("FAIL idle_quiet cycle %0d: got ctl=%b rdata=%h required ctl=0 rdata=%h", c, {ram_ena, ram_wea, ram_enb, busy, ready}, rdata, last_rdata);
            end
        end
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h40; wdata = 32'h5555;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ram_wea !== 1'b1) begin
            n_errors++; $display("FAIL access_wea_before_reset: got %b required 1", ram_wea);
        end
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        n_checks++;
        if ({ram_ena, ram_wea, busy, ready} !== 4'b0) begin
            n_errors++; $display("FAIL async_reset_strobes: got %b required 0", {ram_ena, ram_wea, busy, ready});
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem1[8'h40] !== 32'h0000_AAAA) begin
            n_errors++; $display("FAIL no_partial_write: got %h required %h", mem1[8'h40], 32'h0000_AAAA);
        end
        n_checks++;
        if (rdata !== 32'h0 || ram_addra !== 8'h0 || ram_dina !== 32'h0) begin
            n_errors++; $display("FAIL reset_clears_regs: got rdata=%h addra=%h dina=%h required 0", rdata, ram_addra, ram_dina);
        end
        last_rdata = 32'h0;
        rst_n = 1'b1;
        do_access(1'b0, 8'h40, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; init_mem = 1'b1;
        req = 1'b0; we = 1'b0; addr = 8'h0; wdata = 32'h0;
        req_z = 1'b0; we_z = 1'b0; addr_z = 8'h0; wdata_z = 32'h0;
        last_rdata = 32'h0;
        for (int i = 0; i < 256; i++) model_mem[i] = pattern(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        init_mem = 1'b0;
        rst_n = 1'b1;
        test_write_read();
        test_zero_wait();
        test_busy_change();
        test_back_to_back();
        test_idle();
        test_reset_in_access();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width toward the dual-port block memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter WAIT_CYCLES, default 1, extra wait states inserted before each memory access; the legal range is 0..15.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port req  input  1  CPU access request; the initiator SHALL hold it and all request fields stable until ready.
REQ-007 Port we  input  1  1 = write, 0 = read.
REQ-008 Port addr  input  ADDR_W  word address.
REQ-009 Port wdata  input  DATA_W  write data.
REQ-010 Port ready  output  1  one-cycle completion pulse.
REQ-011 Port rdata  output  DATA_W  read result; it is valid when ready is high for a read.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port ram_ena  output  1  port-A (write) enable.
REQ-014 Port ram_wea  output  1  port-A write strobe.
REQ-015 Port ram_addra  output  ADDR_W  port-A address.
REQ-016 Port ram_dina  output  DATA_W  port-A write data.
REQ-017 Port ram_enb  output  1  port-B (read) enable.
REQ-018 Port ram_addrb  output  ADDR_W  port-B address.
REQ-019 Port ram_doutb  input  DATA_W  port-B read data, valid one clock after ram_enb is sampled.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT, ACCESS, READ and RESP, one-hot or binary encoded, with Moore outputs only.
REQ-021 In IDLE, with req=1 at a rising edge, the block SHALL latch we/addr/wdata into internal registers and go to WAIT, or to ACCESS if WAIT_CYCLES=0.
REQ-022 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded on acceptance, then go to ACCESS.
REQ-023 ACCESS SHALL last one cycle and drive the latched address.
- Write: ram_ena=ram_wea=1 and ram_dina=latched wdata; next state is RESP.
- Read: ram_enb=1; next state is READ.
REQ-024 READ SHALL last one cycle; at its closing edge rdata<=ram_doutb and the next state is RESP.
REQ-025 RESP SHALL last one cycle with ready=1, then return to IDLE; a new req is sampled no earlier than the IDLE cycle that follows.
REQ-026 Latency, counted from the accepting edge (W = WAIT_CYCLES):
- A write SHALL have ready high in the cycle after edge W+1.
- A read SHALL have ready high in the cycle after edge W+2.
REQ-027 Outside ACCESS, ram_ena, ram_wea and ram_enb SHALL be 0; the RAM addresses and ram_dina SHALL equal the latched registers.
REQ-028 rdata SHALL hold its last read value across writes and idle cycles; writes SHALL NOT modify it.
REQ-029 Changes to req/we/addr/wdata while busy SHALL be ignored; only the values latched at acceptance are used.
REQ-030 A read issued after a completed write to the same address SHALL return the written data, because port A writes before the responder reports ready.
REQ-031 req=1 held through RESP SHALL be treated as a new request, accepted at the first IDLE edge.

Reset
REQ-032 When rst_n=0, the block SHALL immediately force state=IDLE, counter=0, latched registers=0 and rdata=0.
REQ-033 Because the outputs are decoded from state, ready, busy, ram_ena, ram_wea and ram_enb SHALL all fall to 0 as soon as rst_n goes low, with no clock needed.
REQ-034 A reset during ACCESS SHALL leave no partial write after reset asserts.
REQ-035 After rst_n deasserts, the first request SHALL be accepted at the first rising edge that sees req=1.

Structure
REQ-036 The state encoding typedef and the ADDR_W/DATA_W defaults SHALL live in the shared CPU package, mem_pkg.
REQ-037 The wait-state counter SHALL be a sub-module named wait_counter, with load, count and zero-flag functions.
REQ-038 The RAM itself SHALL stay outside this block; the expected RTL size is about 150-250 lines.

Verification
REQ-039 Write then read, WAIT_CYCLES=1: write addr 0x10 with data 0xDEADBEEF gives ready in the cycle after edge 2; a read of 0x10 then gives ready in the cycle after edge 3 with rdata=0xDEADBEEF.
REQ-040 WAIT_CYCLES=0: a read of an address preloaded with 0x12345678 gives ready in the cycle after edge 2 with rdata=0x12345678, and ram_enb high for exactly one cycle.
REQ-041 Request field change while busy: accept a write to 0x20 with data 0x1, then change addr to 0x30 and wdata to 0x2 during WAIT; memory[0x20]=0x1 and memory[0x30] is unchanged.
REQ-042 Reset during ACCESS of a write to 0x40, with old data 0xAAAA and asserted at ACCESS mid-cycle: ram_wea drops immediately, memory[0x40] stays 0xAAAA, and rdata=0.
REQ-043 Back-to-back requests with req held high across 3 reads of addresses 0,1,2: exactly 3 ready pulses, each separated by at least one IDLE cycle, returning the preloaded data in order.
REQ-044 Idle, req=0 for 20 cycles: all RAM strobes stay 0, busy=0 and rdata is unchanged.
